// File: rtl/mpu_pkg.sv
// Shared matrix-unit definitions: opcode nibbles, the issuer state encoding
// and the per-opcode hold-length helper used by the instruction issuer.
package mpu_pkg;

    localparam logic [3:0] OP_LOAD   = 4'b0100;
    localparam logic [3:0] OP_COPY   = 4'b0101;
    localparam logic [3:0] OP_UNLOAD = 4'b0110;
    localparam logic [3:0] OP_CLEAR  = 4'b0111;
    localparam logic [3:0] OP_ADD    = 4'b1100;
    localparam logic [3:0] OP_SHIFT  = 4'b1101;
    localparam logic [3:0] OP_SUB    = 4'b1110;
    localparam logic [3:0] OP_MULT   = 4'b1111;

    localparam logic [7:0] INSTR_NOP         = 8'h00;
    localparam int         BURST_LEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_WAIT_FSM = 2'd0,
        ST_READY    = 2'd1,
        ST_HOLD     = 2'd2,
        ST_GAP      = 2'd3
    } issuer_state_t;

    // Cycles the FSM needs the instruction present: one decode cycle in IDLE
    // plus its execute cycles (a full burst for LOAD/UNLOAD, one otherwise).
    function automatic int unsigned op_hold_len(input logic [3:0] op,
                                                input int unsigned burst_len);
        if (op == OP_LOAD || op == OP_UNLOAD) begin
            return burst_len + 1;
        end
        return 2;
    endfunction

    function automatic logic is_nop_class(input logic [7:0] instr);
        return instr[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is always visible on
// dout so the issuer can register it in the same cycle it pops.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_push = push && !full && !reset;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Host instruction queue and issue sequencer feeding the matrix-unit FSM.
// Define INSTR_ISSUER_STATS_EN to add the issued_count/nop_dropped counters.
module instr_issuer
    import mpu_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_valid,
    input  logic [7:0]             host_instr,
    output logic                   host_ready,
    input  logic                   fsm_busy,
    output logic [7:0]             host_instruction,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   issuer_idle
`ifdef INSTR_ISSUER_STATS_EN
    ,
    output logic [15:0]            issued_count,
    output logic [7:0]             nop_dropped
`endif
);

    localparam int HW = $clog2(BURST_LEN + 2);

    issuer_state_t  state_reg;
    logic [7:0]     instr_reg;
    logic [HW-1:0]  hold_cnt_reg;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic           accept;

    assign host_ready = !fifo_full && !reset;
    assign accept     = host_valid && host_ready;
    // NOP-class instructions complete the handshake but never occupy a slot.
    assign fifo_push  = accept && !is_nop_class(host_instr);
    assign fifo_pop   = (state_reg == ST_READY) && !fifo_empty && !fsm_busy;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (host_instr),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_WAIT_FSM;
            instr_reg    <= INSTR_NOP;
            hold_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_WAIT_FSM: begin
                    instr_reg <= INSTR_NOP;
                    if (!fsm_busy) begin
                        state_reg <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (fifo_pop) begin
                        instr_reg    <= fifo_dout;
                        hold_cnt_reg <= HW'(op_hold_len(fifo_dout[3:0], BURST_LEN));
                        state_reg    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // fsm_busy is deliberately ignored: the hold length alone
                    // defines how long the FSM sees the instruction.
                    hold_cnt_reg <= hold_cnt_reg - 1'b1;
                    if (hold_cnt_reg == HW'(1)) begin
                        instr_reg <= INSTR_NOP;
                        state_reg <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_reg <= ST_READY;
                end
                default: begin
                    instr_reg <= INSTR_NOP;
                    state_reg <= ST_WAIT_FSM;
                end
            endcase
        end
    end

    assign host_instruction = instr_reg;
    assign issuer_idle      = fifo_empty && (state_reg == ST_READY) && (instr_reg == INSTR_NOP);

`ifdef INSTR_ISSUER_STATS_EN
    logic [15:0] issued_count_reg;
    logic [7:0]  nop_dropped_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_count_reg <= '0;
            nop_dropped_reg  <= '0;
        end else begin
            if (fifo_pop && issued_count_reg != 16'hFFFF) begin
                issued_count_reg <= issued_count_reg + 1'b1;
            end
            if (accept && is_nop_class(host_instr) && nop_dropped_reg != 8'hFF) begin
                nop_dropped_reg <= nop_dropped_reg + 1'b1;
            end
        end
    end

    assign issued_count = issued_count_reg;
    assign nop_dropped  = nop_dropped_reg;
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_instr_issuer;
    import mpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int BURST = BURST_LEN_DEFAULT;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       host_valid = 1'b0;
    logic [7:0] host_instr = 8'h00;
    logic       fsm_busy   = 1'b1;
    logic       host_ready;
    logic [7:0] host_instruction;
    logic [2:0] pending;
    logic       issuer_idle;
`ifdef INSTR_ISSUER_STATS_EN
    logic [15:0] issued_count;
    logic [7:0]  nop_dropped;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_issuer #(
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .host_valid       (host_valid),
        .host_instr       (host_instr),
        .host_ready       (host_ready),
        .fsm_busy         (fsm_busy),
        .host_instruction (host_instruction),
        .pending          (pending),
        .issuer_idle      (issuer_idle)
`ifdef INSTR_ISSUER_STATS_EN
        ,
        .issued_count     (issued_count),
        .nop_dropped      (nop_dropped)
`endif
    );

    // Reference model: a queue of waiting instructions plus edge timestamps
    // marking when the current instruction turns into NOP and when the next
    // issue is allowed.
    logic [7:0] mq [$];
    logic [7:0] m_cur      = 8'h00;
    int         m_nop_at   = 0;
    int         m_ready_at = 0;
    int         edge_n     = 0;
    bit         m_wait     = 1'b1;
    int         m_issued   = 0;
    int         m_dropped  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] ins, input logic b);
        bit acc;
        bit pop;
        int hold;
        reset      = r;
        host_valid = v;
        host_instr = ins;
        fsm_busy   = b;
        @(posedge clk);
        edge_n++;
        if (r) begin
            mq.delete();
            m_cur      = 8'h00;
            m_nop_at   = 0;
            m_ready_at = 0;
            m_wait     = 1'b1;
            m_issued   = 0;
            m_dropped  = 0;
        end else begin
            acc = v && (mq.size() < DEPTH);
            pop = !m_wait && (edge_n >= m_ready_at) && (mq.size() > 0) && !b;
            if (m_wait && !b) begin
                m_wait     = 1'b0;
                m_ready_at = edge_n + 1;
            end
            if (pop) begin
                m_cur      = mq.pop_front();
                hold       = (m_cur[3:0] == OP_LOAD || m_cur[3:0] == OP_UNLOAD) ? BURST + 1 : 2;
                m_nop_at   = edge_n + hold;
                m_ready_at = edge_n + hold + 2;
                if (m_issued < 65535) m_issued++;
                $display("ISSUE edge %0d instr %h hold %0d queued %0d", edge_n, m_cur, hold, mq.size());
            end
            if (acc) begin
                if (ins[3:2] == 2'b00) begin
                    if (m_dropped < 255) m_dropped++;
                end else begin
                    mq.push_back(ins);
                end
            end
        end
        #1;
        chk("model host_instruction", 32'(host_instruction),
            32'((edge_n < m_nop_at) ? m_cur : INSTR_NOP));
        chk("model pending", 32'(pending), 32'(mq.size()));
        chk("model host_ready", 32'(host_ready), 32'(!r && (mq.size() < DEPTH)));
        chk("model issuer_idle", 32'(issuer_idle),
            32'(!m_wait && (mq.size() == 0) && (edge_n >= m_ready_at - 1)));
`ifdef INSTR_ISSUER_STATS_EN
        chk("model issued_count", 32'(issued_count), 32'(m_issued));
        chk("model nop_dropped", 32'(nop_dropped), 32'(m_dropped));
`endif
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] ins;
        logic       busy;
        logic [7:0] e_hi;
        logic [2:0] e_pend;
        logic       e_rdy;
        logic       e_idle;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] ins,
                                input logic b, input logic [7:0] hi, input logic [2:0] pend,
                                input logic rdy, input logic idle);
        vec_t t;
        t.rst = r; t.v = v; t.ins = ins; t.busy = b;
        t.e_hi = hi; t.e_pend = pend; t.e_rdy = rdy; t.e_idle = idle;
        return t;
    endfunction

    vec_t       tbl [14];
    logic [3:0] op_tab [10];
    logic [7:0] seq_in [5];
    logic [7:0] seen [$];

    initial begin
        int first84;
        int first0e;
        int cnt84;
        logic [7:0] prev;
        logic [7:0] ins;
        logic [3:0] op;

        // Reset, WAIT_FSM exit, one ADD, then two NOP-class pushes.
        tbl[0]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
        tbl[1]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
        tbl[2]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
        tbl[3]  = mk(0, 0, 8'h00, 1, 8'h00, 0, 1, 0);
        tbl[4]  = mk(0, 0, 8'h00, 1, 8'h00, 0, 1, 0);
        tbl[5]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 1);
        tbl[6]  = mk(0, 1, 8'h4C, 0, 8'h00, 1, 1, 0);
        tbl[7]  = mk(0, 0, 8'h00, 0, 8'h4C, 0, 1, 0);
        tbl[8]  = mk(0, 0, 8'h00, 0, 8'h4C, 0, 1, 0);
        tbl[9]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        tbl[10] = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 1);
        tbl[11] = mk(0, 1, 8'hF0, 0, 8'h00, 0, 1, 1);
        tbl[12] = mk(0, 1, 8'h01, 0, 8'h00, 0, 1, 1);
        tbl[13] = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 1);

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].ins, tbl[i].busy);
            chk($sformatf("vec%0d host_instruction", i), 32'(host_instruction), 32'(tbl[i].e_hi));
            chk($sformatf("vec%0d pending", i), 32'(pending), 32'(tbl[i].e_pend));
            chk($sformatf("vec%0d host_ready", i), 32'(host_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d issuer_idle", i), 32'(issuer_idle), 32'(tbl[i].e_idle));
        end
`ifdef INSTR_ISSUER_STATS_EN
        chk("stats nop_dropped after two NOP pushes", 32'(nop_dropped), 32'd2);
        chk("stats issued_count after one ADD", 32'(issued_count), 32'd1);
`endif

        // LOAD held a full burst, SUB issued BURST+3 edges after it.
        first84 = -1; first0e = -1; cnt84 = 0;
        for (int i = 0; i < 82; i++) begin
            if (i == 0)      cycle(0, 1, 8'h84, 0);
            else if (i == 1) cycle(0, 1, 8'h0E, 0);
            else             cycle(0, 0, 8'h00, 0);
            if (host_instruction == 8'h84) begin
                cnt84++;
                if (first84 < 0) first84 = edge_n;
            end
            if (host_instruction == 8'h0E && first0e < 0) first0e = edge_n;
        end
        chk("load hold length", 32'(cnt84), 32'(BURST + 1));
        chk("load to sub spacing", 32'(first0e - first84), 32'(BURST + 3));
        for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 0);

        // Fill while the FSM is busy: fifth push refused, then in-order drain.
        seq_in[0] = 8'h4C; seq_in[1] = 8'h9D; seq_in[2] = 8'h2E;
        seq_in[3] = 8'hFF; seq_in[4] = 8'h37;
        for (int j = 0; j < 5; j++) begin
            cycle(0, 1, seq_in[j], 1);
            if (j >= 3) begin
                chk("full pending", 32'(pending), 32'd4);
                chk("full host_ready", 32'(host_ready), 32'd0);
            end
        end
        seen.delete();
        prev = 8'h00;
        for (int i = 0; i < 24; i++) begin
            cycle(0, 0, 8'h00, 0);
            if (host_instruction != 8'h00 && prev == 8'h00) seen.push_back(host_instruction);
            prev = host_instruction;
        end
        chk("drain issue count", 32'(seen.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < seen.size()) chk($sformatf("drain order %0d", j), 32'(seen[j]), 32'(seq_in[j]));
        end

        // Reset in the middle of a LOAD hold with another op queued.
        cycle(0, 1, 8'h84, 0);
        cycle(0, 1, 8'h0E, 0);
        for (int i = 0; i < 28; i++) cycle(0, 0, 8'h00, 0);
        chk("mid-load still holding", 32'(host_instruction), 32'h84);
        cycle(1, 0, 8'h00, 0);
        chk("reset mid-load host_instruction", 32'(host_instruction), 32'h00);
        chk("reset mid-load pending", 32'(pending), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 8'h00, 1);
            chk("wait_fsm not idle", 32'(issuer_idle), 32'd0);
        end
        cycle(0, 0, 8'h00, 0);
        chk("wait_fsm exit idle", 32'(issuer_idle), 32'd1);

        // Randomized traffic, busy toggling and rare resets.
        op_tab[0] = OP_LOAD;  op_tab[1] = OP_COPY;  op_tab[2] = OP_UNLOAD; op_tab[3] = OP_CLEAR;
        op_tab[4] = OP_ADD;   op_tab[5] = OP_SHIFT; op_tab[6] = OP_SUB;    op_tab[7] = OP_MULT;
        op_tab[8] = 4'h0;     op_tab[9] = 4'h3;
        for (int i = 0; i < 4000; i++) begin
            op = op_tab[$urandom_range(0, 9)];
            if ((op == OP_LOAD || op == OP_UNLOAD) && $urandom_range(0, 3) != 0) op = OP_ADD;
            ins = {4'($urandom_range(0, 15)), op};
            cycle(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), ins,
                  ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
